// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcode constants,
// the core reset PC and the BTB entry layout.
package branch_predictor_pkg;

  // Widest address the BTB entry layout is sized for; narrower XLEN values are zero-extended.
  localparam int unsigned PKG_XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  // Tag is stored zero-extended, so the unused upper bits stay constant zero.
  typedef struct packed {
    logic                valid;
    logic [PKG_XLEN-1:0] tag;
    logic [PKG_XLEN-1:0] target;
    logic                is_jump;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter_table.sv
// Pattern history table: DEPTH saturating counters of CTR_BITS each, one
// combinational read port for fetch and one write port for resolve.
module sat_counter_table #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [CTR_BITS-1:0]      rd_ctr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic                     wr_up
);

  // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for a 1-bit counter.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_d [DEPTH];

  // One saturating step towards taken (up) or not-taken.
  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic up);
    logic [CTR_BITS-1:0] r;
    r = c;
    if (up) begin
      if (c != CTR_MAX) r = c + CTR_BITS'(1);
      else              r = c;
    end else begin
      if (c != CTR_MIN) r = c - CTR_BITS'(1);
      else              r = c;
    end
    return r;
  endfunction

  // Fetch read sees the pre-update contents; there is no write-to-read bypass.
  always_comb begin
    rd_ctr = ctr_q[rd_idx];
  end

  // Next-state: only the addressed counter moves on a resolve.
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = sat_step(ctr_q[wr_idx], wr_up);
    end else begin
      ctr_d = ctr_q;
    end
  end

  // Counter storage with synchronous active-low reset to weakly not-taken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a PHT of saturating
// counters (bimodal or gshare). Fetch looks up combinationally; execute
// resolves, receives the redirect and trains the tables.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned MODE        = 0,
  parameter int unsigned GHR_BITS    = 6,
  parameter int unsigned STAT_BITS   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 f_valid,
  input  logic [XLEN-1:0]      f_pc,
  output logic                 f_pred_taken,
  output logic [XLEN-1:0]      f_pred_target,
  input  logic                 u_valid,
  input  logic [XLEN-1:0]      u_pc,
  input  logic                 u_is_cond,
  input  logic                 u_taken,
  input  logic [XLEN-1:0]      u_target,
  input  logic                 u_pred_taken,
  input  logic [XLEN-1:0]      u_pred_target,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [STAT_BITS-1:0] perf_branches,
  output logic [STAT_BITS-1:0] perf_mispredicts
);

  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
  localparam int unsigned TAG_W  = XLEN - BTB_IW - 2;

  btb_entry_t btb_q [BTB_ENTRIES];
  btb_entry_t btb_d [BTB_ENTRIES];
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;
  logic [STAT_BITS-1:0] perf_branches_q, perf_branches_d;
  logic [STAT_BITS-1:0] perf_mispredicts_q, perf_mispredicts_d;

  logic [BTB_IW-1:0] f_btb_idx_s, u_btb_idx_s;
  logic [TAG_W-1:0]  f_tag_s, u_tag_s;
  logic [PHT_IW-1:0] f_pht_idx_s, u_pht_idx_s;
  logic [CTR_BITS-1:0] f_ctr_s;
  btb_entry_t        f_entry_s;
  logic              f_hit_s;
  logic              u_taken_eff_s;
  logic              pht_wr_en_s;

  // Low PC bits are always 00 for RV32I; u_pred_taken is carried for diagnostics only.
  logic unused_ok_s;
  assign unused_ok_s = ^{f_pc[1:0], u_pc[1:0], u_pred_taken};

  // Index and tag extraction; gshare folds the committed global history into the PHT index.
  always_comb begin
    f_btb_idx_s = f_pc[BTB_IW+1:2];
    u_btb_idx_s = u_pc[BTB_IW+1:2];
    f_tag_s     = f_pc[XLEN-1:BTB_IW+2];
    u_tag_s     = u_pc[XLEN-1:BTB_IW+2];
    if (MODE == 1) begin
      f_pht_idx_s = f_pc[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
      u_pht_idx_s = u_pc[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
    end else begin
      f_pht_idx_s = f_pc[PHT_IW+1:2];
      u_pht_idx_s = u_pc[PHT_IW+1:2];
    end
  end

  assign pht_wr_en_s = u_valid && u_is_cond;

  sat_counter_table #(
    .DEPTH    (PHT_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clock  (clock),
    .reset  (reset),
    .rd_idx (f_pht_idx_s),
    .rd_ctr (f_ctr_s),
    .wr_en  (pht_wr_en_s),
    .wr_idx (u_pht_idx_s),
    .wr_up  (u_taken)
  );

  // Zero-latency lookup: jumps always predict taken on a hit, branches follow the counter MSB.
  always_comb begin
    f_entry_s = btb_q[f_btb_idx_s];
    f_hit_s   = f_entry_s.valid && (f_entry_s.tag == PKG_XLEN'(f_tag_s));
    if (f_valid && f_hit_s && (f_entry_s.is_jump || f_ctr_s[CTR_BITS-1])) begin
      f_pred_taken  = 1'b1;
      f_pred_target = XLEN'(f_entry_s.target);
    end else begin
      f_pred_taken  = 1'b0;
      f_pred_target = f_pc + XLEN'(32'd4);
    end
  end

  // Resolve: a mispredict is any disagreement between the real and the carried next PC.
  always_comb begin
    u_taken_eff_s = u_taken || !u_is_cond;
    if (u_taken_eff_s) begin
      redirect_pc = u_target;
    end else begin
      redirect_pc = u_pc + XLEN'(32'd4);
    end
    redirect = u_valid && (redirect_pc != u_pred_target);
  end

  // Next-state for BTB, GHR and saturating performance counters.
  always_comb begin
    btb_d              = btb_q;
    ghr_d              = ghr_q;
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (u_valid) begin
      if (u_taken_eff_s) begin
        btb_d[u_btb_idx_s] = '{valid:   1'b1,
                               tag:     PKG_XLEN'(u_tag_s),
                               target:  PKG_XLEN'(u_target),
                               is_jump: !u_is_cond};
      end else begin
        btb_d = btb_q;
      end
      if ((MODE == 1) && u_is_cond) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], u_taken};
      end else begin
        ghr_d = ghr_q;
      end
      if (perf_branches_q != {STAT_BITS{1'b1}}) begin
        perf_branches_d = perf_branches_q + STAT_BITS'(1);
      end else begin
        perf_branches_d = perf_branches_q;
      end
      if (redirect && (perf_mispredicts_q != {STAT_BITS{1'b1}})) begin
        perf_mispredicts_d = perf_mispredicts_q + STAT_BITS'(1);
      end else begin
        perf_mispredicts_d = perf_mispredicts_q;
      end
    end else begin
      btb_d = btb_q;
    end
  end

  // State registers; reset takes priority over a resolve in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_q[i] <= '0;
      end
      ghr_q              <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      btb_q              <= btb_d;
      ghr_q              <= ghr_d;
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one bimodal and one gshare predictor share stimulus;
// expected values are hand-computed.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        u_valid;
  logic [31:0] u_pc;
  logic        u_is_cond;
  logic        u_taken;
  logic [31:0] u_target;
  logic        u_pred_taken;
  logic [31:0] u_pred_target;

  logic        f_pred_taken_m0, f_pred_taken_m1;
  logic [31:0] f_pred_target_m0, f_pred_target_m1;
  logic        redirect_m0, redirect_m1;
  logic [31:0] redirect_pc_m0, redirect_pc_m1;
  logic [31:0] perf_br_m0, perf_br_m1, perf_mp_m0, perf_mp_m1;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clock = ~clock;

  branch_predictor #(.MODE(0)) dut0 (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken_m0), .f_pred_target(f_pred_target_m0),
    .u_valid(u_valid), .u_pc(u_pc), .u_is_cond(u_is_cond), .u_taken(u_taken),
    .u_target(u_target), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .redirect(redirect_m0), .redirect_pc(redirect_pc_m0),
    .perf_branches(perf_br_m0), .perf_mispredicts(perf_mp_m0)
  );

  branch_predictor #(.MODE(1)) dut1 (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken_m1), .f_pred_target(f_pred_target_m1),
    .u_valid(u_valid), .u_pc(u_pc), .u_is_cond(u_is_cond), .u_taken(u_taken),
    .u_target(u_target), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .redirect(redirect_m1), .redirect_pc(redirect_pc_m1),
    .perf_branches(perf_br_m1), .perf_mispredicts(perf_mp_m1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    u_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic lookup0(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tg);
    f_valid = 1'b1;
    f_pc    = pc;
    #1;
    check({tag, "_taken"}, f_pred_taken_m0, exp_tk);
    check({tag, "_target"}, f_pred_target_m0, exp_tg);
  endtask

  // Resolve one instruction on both DUTs; returns dut0's resolve outputs.
  task automatic resolve(input logic [31:0] pc, input logic is_cond, input logic taken,
                         input logic [31:0] target, input logic [31:0] pred_target,
                         output logic redir, output logic [31:0] rpc);
    u_valid = 1'b1; u_pc = pc; u_is_cond = is_cond; u_taken = taken;
    u_target = target; u_pred_taken = 1'b0; u_pred_target = pred_target;
    #1;
    redir = redirect_m0;
    rpc   = redirect_pc_m0;
    tick();
    u_valid = 1'b0;
  endtask

  // Pipeline model: the prediction made at fetch travels with the instruction to resolve.
  task automatic run_pred(input bit sel, input logic [31:0] pc, input logic is_cond,
                          input logic taken, input logic [31:0] target, inout int n);
    f_valid = 1'b1;
    f_pc    = pc;
    #1;
    u_pred_target = sel ? f_pred_target_m1 : f_pred_target_m0;
    u_pred_taken  = sel ? f_pred_taken_m1 : f_pred_taken_m0;
    u_valid = 1'b1; u_pc = pc; u_is_cond = is_cond; u_taken = taken; u_target = target;
    #1;
    if ((sel ? redirect_m1 : redirect_m0) === 1'b1) n++;
    tick();
    u_valid = 1'b0;
  endtask

  initial begin
    logic        rd;
    logic [31:0] rp;
    reset = 1'b0; f_valid = 1'b1; f_pc = 32'h0100_0010;
    u_valid = 1'b0; u_pc = '0; u_is_cond = 1'b0; u_taken = 1'b0;
    u_target = '0; u_pred_taken = 1'b0; u_pred_target = '0;

    // Reset: prediction already 0 after the first edge
    tick();
    check("rst_first_edge_taken", f_pred_taken_m0, 1'b0);
    tick();
    reset = 1'b1;
    lookup0("rst_lookup", 32'h0100_0010, 1'b0, 32'h0100_0014);
    check("rst_perf_br", perf_br_m0, 32'd0);
    check("rst_perf_mp", perf_mp_m0, 32'd0);

    // First taken conditional: redirect, then counter 1->2 and BTB hit
    resolve(32'h0100_0010, 1'b1, 1'b1, 32'h0100_0000, 32'h0100_0014, rd, rp);
    check("first_tk_redirect", rd, 1'b1);
    check("first_tk_redirect_pc", rp, 32'h0100_0000);
    lookup0("first_tk_after", 32'h0100_0010, 1'b1, 32'h0100_0000);
    check("first_tk_perf_br", perf_br_m0, 32'd1);
    check("first_tk_perf_mp", perf_mp_m0, 32'd1);

    // Loop branch: 9 taken then exit -> 2 mispredicts
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      run_pred(1'b0, 32'h0100_0030, 1'b1, (i < 9) ? 1'b1 : 1'b0, 32'h0100_0000, cnt);
    end
    check("loop_redirects", cnt, 32'd2);
    check("loop_perf_br", perf_br_m0, 32'd10);
    check("loop_perf_mp", perf_mp_m0, 32'd2);
    lookup0("loop_after_exit", 32'h0100_0030, 1'b1, 32'h0100_0000);

    // JAL: always taken on hit; aliasing not-taken conditional leaves entry intact
    resolve(32'h0100_0020, 1'b0, 1'b1, 32'h0100_0100, 32'h0100_0024, rd, rp);
    check("jal_redirect", rd, 1'b1);
    check("jal_redirect_pc", rp, 32'h0100_0100);
    lookup0("jal_lookup", 32'h0100_0020, 1'b1, 32'h0100_0100);
    resolve(32'h0100_0120, 1'b1, 1'b0, 32'h0100_0200, 32'h0100_0124, rd, rp);
    check("alias_nt_redirect", rd, 1'b0);
    check("alias_nt_redirect_pc", rp, 32'h0100_0124);
    lookup0("jal_after_alias_nt", 32'h0100_0020, 1'b1, 32'h0100_0100);
    lookup0("alias_nt_lookup", 32'h0100_0120, 1'b0, 32'h0100_0124);
    f_valid = 1'b0;
    #1;
    check("fvalid_low_taken", f_pred_taken_m0, 1'b0);

    // Same-cycle lookup/update returns pre-update contents; tag mismatch predicts not-taken
    f_valid = 1'b1; f_pc = 32'h0100_0010;
    u_valid = 1'b1; u_pc = 32'h0100_0010; u_is_cond = 1'b1; u_taken = 1'b1;
    u_target = 32'h0100_0000; u_pred_target = 32'h0100_0014;
    #1;
    check("same_cycle_preupdate", f_pred_taken_m0, 1'b0);
    tick();
    u_valid = 1'b0;
    lookup0("alias_trained", 32'h0100_0010, 1'b1, 32'h0100_0000);
    lookup0("alias_other_tag", 32'h0100_0050, 1'b0, 32'h0100_0054);

    // gshare: alternating T/N settles after 4 mispredicts
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      run_pred(1'b1, 32'h0100_0040, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 32'h0100_0000, cnt);
    end
    check("gshare_redirects", cnt, 32'd4);
    check("gshare_perf_br", perf_br_m1, 32'd20);
    check("gshare_perf_mp", perf_mp_m1, 32'd4);

    // Mid-sequence reset with a resolve on the same edge: everything cleared
    for (int i = 0; i < 3; i++) begin
      run_pred(1'b1, 32'h0100_0040, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 32'h0100_0000, cnt);
    end
    reset = 1'b0;
    u_valid = 1'b1; u_pc = 32'h0100_0040; u_is_cond = 1'b1; u_taken = 1'b1;
    u_target = 32'h0100_0000; u_pred_target = 32'h0100_0044;
    tick();
    reset = 1'b1;
    u_valid = 1'b0;
    f_valid = 1'b1; f_pc = 32'h0100_0040;
    #1;
    check("midrst_taken", f_pred_taken_m1, 1'b0);
    check("midrst_target", f_pred_target_m1, 32'h0100_0044);
    check("midrst_perf_br", perf_br_m1, 32'd0);
    check("midrst_perf_mp", perf_mp_m1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
